// File: rtl/bsg_tie_cfg_pkg.sv
//------------------------------------------------------------------------------
// Module   : bsg_tie_cfg_pkg
// Brief    : Shared state encoding and address-width helper for bsg_tie_cfg_bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bsg_tie_cfg_pkg;

  typedef enum logic [1:0] {
    eSettle = 2'd0,
    eOpen   = 2'd1,
    eLocked = 2'd2
  } bsg_tie_cfg_state_e;

  // A single-channel bank still needs a one-bit address port.
  function automatic int bsg_tie_cfg_addr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_tie_cfg_settle_ctr.sv
//------------------------------------------------------------------------------
// Module   : bsg_tie_cfg_settle_ctr
// Brief    : Loadable saturating down-counter with a done flag at zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_tie_cfg_settle_ctr #(
  parameter int                 width_p    = 2,
  parameter logic [width_p-1:0] init_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               dec_i,
  output logic               done_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= init_val_p;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/bsg_tie_cfg_bank.sv
//------------------------------------------------------------------------------
// Module   : bsg_tie_cfg_bank
// Brief    : Programmable tie-value bank with settle window and one-way lock.
//            Optional readback port enabled by BSG_TIE_CFG_BANK_READBACK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_tie_cfg_bank
  import bsg_tie_cfg_pkg::*;
#(
  parameter int                 width_p         = 16,
  parameter int                 els_p           = 4,
  parameter logic [width_p-1:0] reset_val_p     = '0,
  parameter int                 settle_cycles_p = 3,
  localparam int                addr_width_lp   = bsg_tie_cfg_addr_width(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  input  logic                     lock_i,
  output logic                     locked_o,
`ifdef BSG_TIE_CFG_BANK_READBACK_EN
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o,
`endif
  output logic [els_p*width_p-1:0] o
);

  localparam int ctr_width_lp = $clog2(settle_cycles_p + 1);

  bsg_tie_cfg_state_e state_q, state_d;
  logic               settle_done;
  logic               wr_en;
  logic [width_p-1:0] ch_q [els_p];

  bsg_tie_cfg_settle_ctr #(
    .width_p    (ctr_width_lp),
    .init_val_p (ctr_width_lp'(settle_cycles_p - 1))
  ) settle_ctr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .dec_i      (state_q == eSettle),
    .done_o     (settle_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      eSettle: begin
        if (lock_i) begin
          state_d = eLocked;
        end else if (settle_done) begin
          state_d = eOpen;
        end
      end
      eOpen: begin
        if (lock_i) begin
          state_d = eLocked;
        end
      end
      eLocked: state_d = eLocked;
      default: state_d = eSettle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eSettle;
    end else begin
      state_q <= state_d;
    end
  end

  assign ready_o  = (state_q == eOpen);
  assign locked_o = (state_q == eLocked);
  assign wr_en    = v_i && (state_q == eOpen);

  // Out-of-range addresses match no channel, so they complete the handshake silently.
  for (genvar k = 0; k < els_p; k++) begin : g_ch
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        ch_q[k] <= reset_val_p;
      end else if (wr_en && (addr_i == addr_width_lp'(k))) begin
        ch_q[k] <= data_i;
      end
    end
    assign o[k*width_p +: width_p] = ch_q[k];
  end

`ifdef BSG_TIE_CFG_BANK_READBACK_EN
  logic [width_p-1:0] r_data_q, r_data_d, r_mux;

  always_comb begin
    r_mux = '0;
    for (int k = 0; k < els_p; k++) begin
      if (r_addr_i == addr_width_lp'(k)) begin
        r_mux = ch_q[k];
      end
    end
    r_data_d = r_v_i ? r_mux : r_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

  assign r_data_o = r_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_tie_cfg_bank.sv
//------------------------------------------------------------------------------
// Module   : tb_bsg_tie_cfg_bank
// Brief    : Self-checking bench for bsg_tie_cfg_bank (4- and 3-channel banks).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_tie_cfg_bank;

  localparam int          SETTLE = 3;
  localparam logic [15:0] RV4    = 16'h0000;
  localparam logic [15:0] RV3    = 16'h00A5;

  logic        clk = 1'b0;
  logic        reset, v, lock;
  logic [1:0]  addr;
  logic [15:0] data;
  logic        ready4, locked4, ready3, locked3;
  logic [63:0] o4;
  logic [47:0] o3;
`ifdef BSG_TIE_CFG_BANK_READBACK_EN
  logic        r_v;
  logic [1:0]  r_addr;
  logic [15:0] rdata4, rdata3;
  logic [15:0] mr4, mr3;
`endif

  always #5 clk = ~clk;

  bsg_tie_cfg_bank #(.width_p(16), .els_p(4), .reset_val_p(RV4), .settle_cycles_p(SETTLE)) dut4 (
    .clk_i(clk), .reset_i(reset), .v_i(v), .addr_i(addr), .data_i(data),
    .ready_o(ready4), .lock_i(lock), .locked_o(locked4),
`ifdef BSG_TIE_CFG_BANK_READBACK_EN
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rdata4),
`endif
    .o(o4)
  );

  bsg_tie_cfg_bank #(.width_p(16), .els_p(3), .reset_val_p(RV3), .settle_cycles_p(SETTLE)) dut3 (
    .clk_i(clk), .reset_i(reset), .v_i(v), .addr_i(addr), .data_i(data),
    .ready_o(ready3), .lock_i(lock), .locked_o(locked3),
`ifdef BSG_TIE_CFG_BANK_READBACK_EN
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rdata3),
`endif
    .o(o3)
  );

  // Reference model: channel arrays, cycles since reset, and a sticky lock flag.
  logic [15:0] m4 [4];
  logic [15:0] m3 [3];
  int          cyc;
  bit          mlocked;
  int          n_chk  = 0;
  int          n_pass = 0;

  typedef struct {
    bit          v;
    logic [1:0]  addr;
    logic [15:0] data;
    bit          lock;
    bit          er;
    bit          el;
    logic [63:0] eo;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_edge();
    bit rdy;
    if (reset) begin
      cyc = 0;
      mlocked = 0;
      for (int k = 0; k < 4; k++) m4[k] = RV4;
      for (int k = 0; k < 3; k++) m3[k] = RV3;
`ifdef BSG_TIE_CFG_BANK_READBACK_EN
      mr4 = '0;
      mr3 = '0;
`endif
    end else begin
      rdy = !mlocked && (cyc >= SETTLE);
`ifdef BSG_TIE_CFG_BANK_READBACK_EN
      if (r_v) begin
        mr4 = m4[r_addr];
        mr3 = (r_addr < 3) ? m3[r_addr] : 16'h0;
      end
`endif
      if (rdy && v) begin
        m4[addr] = data;
        if (addr < 3) m3[addr] = data;
      end
      if (lock) mlocked = 1;
      if (cyc < SETTLE) cyc++;
    end
  endtask

  task automatic compare_all();
    bit er;
    er = !mlocked && (cyc >= SETTLE);
    chk("m_ready4", 64'(ready4), 64'(er));
    chk("m_ready3", 64'(ready3), 64'(er));
    chk("m_locked4", 64'(locked4), 64'(mlocked));
    chk("m_locked3", 64'(locked3), 64'(mlocked));
    chk("m_o4", o4, {m4[3], m4[2], m4[1], m4[0]});
    chk("m_o3", 64'(o3), 64'({m3[2], m3[1], m3[0]}));
`ifdef BSG_TIE_CFG_BANK_READBACK_EN
    chk("m_rdata4", 64'(rdata4), 64'(mr4));
    chk("m_rdata3", 64'(rdata3), 64'(mr3));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; v = 1'b0; addr = '0; data = '0; lock = 1'b0;
`ifdef BSG_TIE_CFG_BANK_READBACK_EN
    r_v = 1'b0; r_addr = '0;
`endif
    tbl[0] = '{1'b1, 2'd2, 16'hBEEF, 1'b0, 1'b1, 1'b0, 64'h0000_BEEF_0000_0000};
    tbl[1] = '{1'b1, 2'd1, 16'h1111, 1'b0, 1'b1, 1'b0, 64'h0000_BEEF_1111_0000};
    tbl[2] = '{1'b0, 2'd3, 16'hFFFF, 1'b0, 1'b1, 1'b0, 64'h0000_BEEF_1111_0000};
    tbl[3] = '{1'b1, 2'd3, 16'hCAFE, 1'b0, 1'b1, 1'b0, 64'hCAFE_BEEF_1111_0000};
    tbl[4] = '{1'b1, 2'd0, 16'h1234, 1'b1, 1'b0, 1'b1, 64'hCAFE_BEEF_1111_1234};
    tbl[5] = '{1'b1, 2'd0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 64'hCAFE_BEEF_1111_1234};
    tbl[6] = '{1'b1, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 64'hCAFE_BEEF_1111_1234};

    // Reset for two cycles, then the settle window.
    step();
    step();
    chk("rst_o4", o4, 64'h0);
    chk("rst_o3", 64'(o3), 64'h00A5_00A5_00A5);
    chk("rst_ready", 64'(ready4), 64'h0);
    chk("rst_locked", 64'(locked4), 64'h0);
    reset = 1'b0;
    for (int i = 0; i < SETTLE - 1; i++) begin
      step();
      chk("settle_ready", 64'(ready4), 64'h0);
    end
    step();
    chk("open_ready", 64'(ready4), 64'h1);
    chk("open_o4", o4, 64'h0);

    for (int i = 0; i < 7; i++) begin
      v = tbl[i].v; addr = tbl[i].addr; data = tbl[i].data; lock = tbl[i].lock;
      step();
      chk("tbl_ready", 64'(ready4), 64'(tbl[i].er));
      chk("tbl_locked", 64'(locked4), 64'(tbl[i].el));
      chk("tbl_o4", o4, tbl[i].eo);
    end
    lock = 1'b0;

    // Reset while locked, with a write held across the whole settle window.
    reset = 1'b1; v = 1'b1; addr = 2'd1; data = 16'h5555;
    step();
    chk("rl_o4", o4, 64'h0);
    chk("rl_locked", 64'(locked4), 64'h0);
    chk("rl_ready", 64'(ready4), 64'h0);
    reset = 1'b0;
    for (int i = 0; i < SETTLE - 1; i++) begin
      step();
      chk("rl_settle_ready", 64'(ready4), 64'h0);
      chk("rl_settle_o4", o4, 64'h0);
    end
    step();
    chk("rl_open_ready", 64'(ready4), 64'h1);
    chk("rl_open_o4", o4, 64'h0);
    step();
    chk("held_write_o4", o4, 64'h0000_0000_5555_0000);
    v = 1'b0;
    step();
    chk("held_write_once", o4, 64'h0000_0000_5555_0000);

`ifdef BSG_TIE_CFG_BANK_READBACK_EN
    v = 1'b1; addr = 2'd1; data = 16'hA5A5;
    step();
    v = 1'b0; r_v = 1'b1; r_addr = 2'd1;
    step();
    chk("rb_basic", 64'(rdata4), 64'hA5A5);
    v = 1'b1; data = 16'h0F0F;
    step();
    chk("rb_same_cycle", 64'(rdata4), 64'hA5A5);
    v = 1'b0; r_v = 1'b0;
    step();
    chk("rb_hold", 64'(rdata4), 64'hA5A5);
    r_v = 1'b1; r_addr = 2'd3;
    step();
    chk("rb_oor3", 64'(rdata3), 64'h0);
    chk("rb_new4", 64'(rdata4), 64'h0);
    r_v = 1'b0;
`endif

    // Randomized traffic with occasional locks and resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      lock  = ($urandom_range(0, 49) == 0);
      v     = 1'($urandom);
      addr  = 2'($urandom);
      data  = 16'($urandom);
`ifdef BSG_TIE_CFG_BANK_READBACK_EN
      r_v    = 1'($urandom);
      r_addr = 2'($urandom);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bsg_tie_cfg_bank.md
# bsg_tie_cfg_bank

Programmable successor to the fixed tie-low cell. Drives `els_p` constant channels of `width_p` bits, each reset to a parameterised tie value and optionally overridden through a valid/ready write port. Overrides are allowed only until a one-way lock is asserted. Sits at chip/tile configuration boundaries where strap values must be trimmable after reset but frozen before mission mode.

## Interface
- `width_p`, 16: bits per channel.
- `els_p`, 4: number of channels, ≥1.
- `reset_val_p`, 0: per-channel reset/tie value, `width_p` bits, applied to every channel.
- `settle_cycles_p`, 3: cycles after reset release during which writes are refused, ≥1.
- `addr_width_lp`, derived as max(1, clog2(`els_p`)).

Ports:
- `clk_i`, in, 1: sole clock.
- `reset_i`, in, 1: synchronous, active-high.
- `v_i`, in, 1: write request valid.
- `addr_i`, in, `addr_width_lp`: target channel.
- `data_i`, in, `width_p`: write value.
- `ready_o`, out, 1: write accepted when `v_i` & `ready_o`.
- `lock_i`, in, 1: one-way lock request.
- `locked_o`, out, 1: lock status.
- `o`, out, `els_p*width_p`: channel k is `o[k*width_p +: width_p]`.

## Operation
- The state machine has three states: `eSettle`, `eOpen` and `eLocked`.
- Reset forces `eSettle`, loads the settle counter with `settle_cycles_p`-1, and sets every channel to `reset_val_p`.
- `eSettle`:
  - `ready_o`=0.
  - Counter decrements each cycle. At 0, go to `eOpen`.
  - `lock_i` in this state goes directly to `eLocked`.
- `eOpen`:
  - `ready_o`=1.
  - An accepted write with `addr_i` < `els_p` loads `data_i` into that channel.
  - A write with `addr_i` ≥ `els_p` is accepted (handshake completes) and has no effect.
  - `lock_i`=1 goes to `eLocked`.
- `eLocked`:
  - `ready_o`=0, `locked_o`=1.
  - Channel values are frozen. Only `reset_i` exits this state.
- Write and `lock_i` in the same `eOpen` cycle: the write takes effect, and the lock applies from the next cycle.
- `v_i` while `ready_o`=0: ignored. The requester must hold `v_i` until accepted; no queuing.
- Data is copied verbatim with no arithmetic. The settle counter is `clog2(settle_cycles_p+1)` bits and saturates at 0.

## Timing
- Reset values (cycle after `reset_i` is sampled high): `o`=all channels `reset_val_p`, `ready_o`=0, `locked_o`=0, state `eSettle`.
- Reset mid-operation (any state, including `eLocked`): same reset values at the next edge. Pending writes are dropped.
- `ready_o` rises exactly `settle_cycles_p` cycles after the first cycle with `reset_i` low.
- Write latency: `o` reflects an accepted write one cycle after acceptance.
- `locked_o` rises one cycle after `lock_i` is sampled. `ready_o` falls in that same cycle.
- All outputs are registered. `ready_o` and `locked_o` are decoded from state flops with no combinational path from inputs.
- Back-to-back writes are sustained at 1/cycle in `eOpen`.

## Configuration
- `BSG_TIE_CFG_BANK_READBACK_EN`:
  - When defined, adds ports `r_v_i` (1), `r_addr_i` (`addr_width_lp`) and `r_data_o` (`width_p`).
  - `r_data_o` returns the addressed channel one cycle after `r_v_i`. It holds its value otherwise and resets to 0.
  - Reads are legal in every state. An out-of-range read returns 0.
  - A read of a channel written in the same cycle returns the old value.
- When undefined, these ports and their logic are absent. The write path and timing are identical in both builds.

## Structure
- Shared package `bsg_tie_cfg_pkg` holds:
  - the state enum `bsg_tie_cfg_state_e` (`eSettle`, `eOpen`, `eLocked`);
  - the address-width helper function.
- One sub-module, `bsg_tie_cfg_settle_ctr`: a loadable down-counter with a `done_o` flag, reused by other strap blocks.
- Channel storage is a flat register array with per-channel write enable decoded from `addr_i`.

## Test plan
- **Reset and settle:** `reset_i` high 2 cycles, then low → `o`=64'h0 and `ready_o` low for 3 cycles, then `ready_o`=1 in cycle 4.
- **Basic write:** in `eOpen`, write addr 2, data 16'hBEEF → next cycle `o[47:32]`=16'hBEEF and all other channels 0.
- **Write with lock:** write addr 0, data 16'h1234 with `lock_i`=1 in the same cycle → `o[15:0]`=16'h1234, `locked_o`=1, `ready_o`=0. A later write addr 0, data 16'hFFFF leaves `o[15:0]` at 16'h1234.
- **Refused and out-of-range writes:**
  - `v_i` held during settle → no change until `ready_o`; then accepted, with exactly one update.
  - With `els_p`=3, `addr_width_lp`=2, write addr 3 → handshake completes, `o` unchanged.
- **Reset while locked:** assert `reset_i` while locked → `o` returns to all `reset_val_p`, `locked_o`=0, and the settle window repeats.
- **Readback (macro defined):** write addr 1, data 16'hA5A5, then `r_v_i` with addr 1 → `r_data_o`=16'hA5A5 one cycle later. A same-cycle read and write returns the prior value.
